program_counter_unit: RTL and testbench
=======================================

# program_counter_unit

Parametrised program-counter block for the instruction-fetch stage of the single-cycle MIPS core. It holds the fetch PC and selects the next PC from sequential, branch, jump, call, return and exception sources. It honours a freeze request and keeps a small circular return-address stack (RAS) for call/return. It replaces the fixed 32-bit PC register and feeds the instruction-memory address and the PC+4 link value.

## Interface
- WIDTH, 32: PC width in bits; minimum 8.
- RESET_VECTOR, 0: PC value loaded on reset.
- EXCEPTION_VECTOR, 32'h0000_0180: PC loaded on exception or RAS underflow; truncated to WIDTH.
- INSTR_BYTES, 4: sequential increment.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- freeze  in  1  hold PC and RAS.
- exception  in  1  redirect to EXCEPTION_VECTOR.
- branchTaken  in  1  redirect to branchTarget.
- branchTarget  in  WIDTH  branch destination.
- jump  in  1  redirect to jumpTarget.
- call  in  1  redirect to jumpTarget and push the link address.
- jumpTarget  in  WIDTH  jump/call destination.
- ret  in  1  redirect to the popped RAS top.
- programCounterOutput  out  WIDTH  current fetch PC (registered).
- programCounterPlusStep  out  WIDTH  programCounterOutput + INSTR_BYTES (combinational, mod 2^WIDTH).
- rasEmpty  out  1  RAS count == 0 (combinational from count).
- rasFull  out  1  RAS count == RAS_DEPTH.
- rasOverflow  out  1  sticky; set when a push overwrites the oldest entry.
- rasUnderflow  out  1  registered one-cycle pulse on ret while empty.

## Operation
- Next-PC priority, highest first:
  1. exception → EXCEPTION_VECTOR.
  2. freeze → hold the PC.
  3. ret → RAS top.
  4. call → jumpTarget.
  5. jump → jumpTarget.
  6. branchTaken → branchTarget.
  7. Otherwise → programCounterPlusStep.
- RAS: circular array, write pointer wp (log2 RAS_DEPTH bits), count 0..RAS_DEPTH.
- Push (call selected): entry[wp] ← programCounterPlusStep; wp ← wp+1 with wrap.
  - Not full: count++.
  - Full: count stays RAS_DEPTH, the oldest entry is overwritten, rasOverflow ← 1 until reset.
- Pop (ret selected): top = entry[wp−1] with wrap.
  - Not empty: PC ← top; wp ← wp−1; count−−.
  - Empty: PC ← EXCEPTION_VECTOR, RAS unchanged, rasUnderflow pulses for one cycle.
- Simultaneous requests:
  - ret+call: ret wins, no push.
  - call+jump: identical target, one push.
  - Any request with freeze: ignored, and no RAS change.
  - exception: RAS untouched, and any co-asserted call/ret is discarded.
- Arithmetic: all sums modulo 2^WIDTH; targets used as given (no alignment check).

## Timing
- Reset asserted (reset=0), asynchronously:
  - programCounterOutput = RESET_VECTOR.
  - wp = 0, count = 0, rasEmpty = 1, rasFull = 0.
  - rasOverflow = 0, rasUnderflow = 0.
  - RAS entries are not cleared.
- Reset released mid-operation: the first update occurs on the first falling edge with reset=1.
- Latency: controls sampled at falling edge N appear on programCounterOutput immediately after edge N; a redirect has one-edge latency.
- A push at edge N makes the pushed value visible as top for a ret sampled at edge N+1.
- rasUnderflow is high for exactly one clock period after the offending edge; it is cleared at the next edge unless re-triggered.
- freeze held for k edges keeps all state constant for those k edges.

## Test plan
- Reset and sequential run: pulse reset low with RESET_VECTOR=0, then run 5 edges with no controls → PC 0,4,8,12,16,20; programCounterPlusStep = PC+4.
- Redirect priority: at PC=0x10 assert branchTaken(0x100), jump(0x200) and exception together → PC=0x180; next edge with only branchTaken(0x100) → 0x100.
- Call/return pair: at PC=0x40 assert call with jumpTarget=0x400 → PC=0x400, count=1; then 3 sequential edges; then ret → PC=0x44, rasEmpty=1.
- RAS overflow, RAS_DEPTH=4: perform 5 calls from PCs 0x0,0x100,0x200,0x300,0x400 → rasFull=1, rasOverflow=1; 4 rets return 0x404,0x304,0x204,0x104; a 5th ret → PC=0x180, rasUnderflow=1 for one cycle.
- Freeze interaction: at PC=0x20 hold freeze with call asserted for 3 edges → PC stays 0x20, count unchanged; exception during freeze → PC=0x180.
- Wrap and async reset: WIDTH=8, PC=0xFC, one sequential edge → 0x00; drive reset low between edges → PC=RESET_VECTOR immediately, with no clock edge needed.

Source files
------------

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter: next-PC selection plus a circular return-address stack.
// All state advances on the falling edge of clk; reset is asynchronous and active-low.
module program_counter_unit #(
  parameter int unsigned      WIDTH            = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR     = '0,
  parameter logic [31:0]      EXCEPTION_VECTOR = 32'h0000_0180,
  parameter int unsigned      INSTR_BYTES      = 4,
  parameter int unsigned      RAS_DEPTH        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             exception,
  input  logic             branchTaken,
  input  logic [WIDTH-1:0] branchTarget,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jumpTarget,
  input  logic             ret,
  output logic [WIDTH-1:0] programCounterOutput,
  output logic [WIDTH-1:0] programCounterPlusStep,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             rasOverflow,
  output logic             rasUnderflow
);

  localparam int unsigned      PTR_W     = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXCEPTION_VECTOR);
  localparam logic [WIDTH-1:0] STEP      = WIDTH'(INSTR_BYTES);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_en;
  logic [WIDTH-1:0] plus_step;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;

  // Stack entries carry no reset: a valid count always guards what is read back.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  assign plus_step = pc_q + STEP;
  assign top_idx   = wp_q - PTR_W'(1);
  assign ras_top   = ras_q[top_idx];
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == DEPTH_CNT);

  always_comb begin
    pc_d        = pc_q;
    wp_d        = wp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = 1'b0;
    push_en     = 1'b0;
    if (exception) begin
      pc_d = EXC_VEC;
    end else if (freeze) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (ras_empty) begin
        pc_d        = EXC_VEC;
        underflow_d = 1'b1;
      end else begin
        pc_d    = ras_top;
        wp_d    = top_idx;
        count_d = count_q - CNT_W'(1);
      end
    end else if (call) begin
      pc_d    = jumpTarget;
      push_en = 1'b1;
      wp_d    = wp_q + PTR_W'(1);
      // A push onto a full stack silently replaces the oldest return address.
      if (ras_full) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (jump) begin
      pc_d = jumpTarget;
    end else if (branchTaken) begin
      pc_d = branchTarget;
    end else begin
      pc_d = plus_step;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_VECTOR;
      wp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      wp_q        <= wp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(negedge clk) begin
    if (reset && push_en) begin
      ras_q[wp_q] <= plus_step;
    end
  end

  assign programCounterOutput   = pc_q;
  assign programCounterPlusStep = plus_step;
  assign rasEmpty               = ras_empty;
  assign rasFull                = ras_full;
  assign rasOverflow            = overflow_q;
  assign rasUnderflow           = underflow_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Bench for program_counter_unit: a 32-bit and an 8-bit instance share stimulus and are
// compared every cycle against a stack-based next-PC model, plus directed literal checks.
module tb_program_counter_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] EXC   = 32'h0000_0180;
  localparam logic [31:0] MASK32 = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK8  = 32'h0000_00FF;

  logic        clk;
  logic        reset;
  logic        freeze, exception, branchTaken, jump, call, ret;
  logic [31:0] branchTarget, jumpTarget;

  logic [31:0] pc32, ps32;
  logic        e32, f32, o32, u32;
  logic [7:0]  pc8, ps8;
  logic        e8, f8, o8, u8;

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;

  // Model state: index 0 models the 32-bit instance, index 1 the 8-bit one.
  // The stack keeps the oldest entry at slot 0 and the top at slot cnt-1.
  logic [31:0] m_pc  [2];
  logic [31:0] m_stk [2][DEPTH];
  int          m_cnt [2];
  logic        m_ovf [2];
  logic        m_unf [2];

  program_counter_unit #(.WIDTH(32), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .exception(exception),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .jump(jump), .call(call),
    .jumpTarget(jumpTarget), .ret(ret),
    .programCounterOutput(pc32), .programCounterPlusStep(ps32),
    .rasEmpty(e32), .rasFull(f32), .rasOverflow(o32), .rasUnderflow(u32)
  );

  program_counter_unit #(.WIDTH(8), .RAS_DEPTH(DEPTH)) dut8 (
    .clk(clk), .reset(reset), .freeze(freeze), .exception(exception),
    .branchTaken(branchTaken), .branchTarget(branchTarget[7:0]), .jump(jump), .call(call),
    .jumpTarget(jumpTarget[7:0]), .ret(ret),
    .programCounterOutput(pc8), .programCounterPlusStep(ps8),
    .rasEmpty(e8), .rasFull(f8), .rasOverflow(o8), .rasUnderflow(u8)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset(input int i);
    m_pc[i]  = 32'h0;
    m_cnt[i] = 0;
    m_ovf[i] = 1'b0;
    m_unf[i] = 1'b0;
  endtask

  task automatic modelStep(input int i, input logic [31:0] mask);
    logic [31:0] ps;
    logic [31:0] ev;
    ps = (m_pc[i] + 32'd4) & mask;
    ev = EXC & mask;
    m_unf[i] = 1'b0;
    if (exception) begin
      m_pc[i] = ev;
    end else if (freeze) begin
      m_pc[i] = m_pc[i];
    end else if (ret) begin
      if (m_cnt[i] == 0) begin
        m_pc[i]  = ev;
        m_unf[i] = 1'b1;
      end else begin
        m_cnt[i] = m_cnt[i] - 1;
        m_pc[i]  = m_stk[i][m_cnt[i]];
      end
    end else if (call) begin
      if (m_cnt[i] == DEPTH) begin
        for (int k = 0; k < DEPTH - 1; k++) m_stk[i][k] = m_stk[i][k+1];
        m_stk[i][DEPTH-1] = ps;
        m_ovf[i] = 1'b1;
      end else begin
        m_stk[i][m_cnt[i]] = ps;
        m_cnt[i] = m_cnt[i] + 1;
      end
      m_pc[i] = jumpTarget & mask;
    end else if (jump) begin
      m_pc[i] = jumpTarget & mask;
    end else if (branchTaken) begin
      m_pc[i] = branchTarget & mask;
    end else begin
      m_pc[i] = ps;
    end
  endtask

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      modelReset(0);
      modelReset(1);
    end else begin
      modelStep(0, MASK32);
      modelStep(1, MASK8);
    end
    armed <= 1'b1;
  end

  // Outputs settle after the falling edge, so the rising edge is a quiet sampling point.
  always @(posedge clk) begin
    if (armed) begin
      checkOutput("pc32", pc32, m_pc[0]);
      checkOutput("step32", ps32, m_pc[0] + 32'd4);
      checkOutput("empty32", {31'b0, e32}, {31'b0, m_cnt[0] == 0});
      checkOutput("full32", {31'b0, f32}, {31'b0, m_cnt[0] == DEPTH});
      checkOutput("ovf32", {31'b0, o32}, {31'b0, m_ovf[0]});
      checkOutput("unf32", {31'b0, u32}, {31'b0, m_unf[0]});
      checkOutput("pc8", {24'b0, pc8}, m_pc[1]);
      checkOutput("step8", {24'b0, ps8}, (m_pc[1] + 32'd4) & MASK8);
      checkOutput("empty8", {31'b0, e8}, {31'b0, m_cnt[1] == 0});
      checkOutput("full8", {31'b0, f8}, {31'b0, m_cnt[1] == DEPTH});
      checkOutput("ovf8", {31'b0, o8}, {31'b0, m_ovf[1]});
      checkOutput("unf8", {31'b0, u8}, {31'b0, m_unf[1]});
    end
  end

  task automatic applyStimulus(input logic exc, input logic frz, input logic br, input logic [31:0] bt,
                               input logic jmp, input logic cl, input logic [31:0] jt, input logic rt);
    exception    = exc;
    freeze       = frz;
    branchTaken  = br;
    branchTarget = bt;
    jump         = jmp;
    call         = cl;
    jumpTarget   = jt;
    ret          = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    exception = 0; freeze = 0; branchTaken = 0; jump = 0; call = 0; ret = 0;
    branchTarget = 0; jumpTarget = 0;
    @(posedge clk);
    #1;
    checkOutput("resetPc", pc32, 32'h0);
    checkOutput("resetEmpty", {31'b0, e32}, 32'h1);
    checkOutput("resetFull", {31'b0, f32}, 32'h0);
    reset = 1'b1;

    for (int n = 1; n <= 5; n++) begin
      idle();
      checkOutput("seqPc", pc32, 32'(4 * n));
      checkOutput("seqStep", ps32, 32'(4 * n + 4));
    end

    applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 0);
    checkOutput("jumpTo10", pc32, 32'h10);
    applyStimulus(1, 0, 1, 32'h100, 1, 0, 32'h200, 0);
    checkOutput("priorityExc", pc32, 32'h180);
    applyStimulus(0, 0, 1, 32'h100, 0, 0, 0, 0);
    checkOutput("branch100", pc32, 32'h100);

    applyStimulus(0, 0, 0, 0, 1, 0, 32'h40, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h400, 0);
    checkOutput("call400", pc32, 32'h400);
    checkOutput("callNotEmpty", {31'b0, e32}, 32'h0);
    repeat (3) idle();
    checkOutput("afterSeq", pc32, 32'h40C);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("ret44", pc32, 32'h44);
    checkOutput("retEmpty", {31'b0, e32}, 32'h1);

    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0, 0);
    for (int n = 1; n <= 5; n++) applyStimulus(0, 0, 0, 0, 0, 1, 32'(n * 32'h100), 0);
    checkOutput("ovfFull", {31'b0, f32}, 32'h1);
    checkOutput("ovfSticky", {31'b0, o32}, 32'h1);
    for (int n = 4; n >= 1; n--) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("ovfRet", pc32, 32'(n * 32'h100 + 4));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("underflowPc", pc32, 32'h180);
    checkOutput("underflowPulse", {31'b0, u32}, 32'h1);
    idle();
    checkOutput("underflowClear", {31'b0, u32}, 32'h0);
    checkOutput("underflowNext", pc32, 32'h184);

    applyStimulus(0, 0, 0, 0, 1, 0, 32'h20, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 1, 32'h300, 0);
    checkOutput("freezePc", pc32, 32'h20);
    checkOutput("freezeEmpty", {31'b0, e32}, 32'h1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("freezeExc", pc32, 32'h180);

    applyStimulus(0, 0, 0, 0, 1, 0, 32'hFC, 0);
    checkOutput("wrapStep8", {24'b0, ps8}, 32'h0);
    idle();
    checkOutput("wrap8", {24'b0, pc8}, 32'h0);
    checkOutput("noWrap32", pc32, 32'h100);
    #1 reset = 1'b0;
    #1;
    checkOutput("asyncReset32", pc32, 32'h0);
    checkOutput("asyncReset8", {24'b0, pc8}, 32'h0);
    checkOutput("asyncResetOvf", {31'b0, o32}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0, $urandom,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom,
                    $urandom_range(0, 4) == 0);
    end

    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
